// File: rtl/r2sdf_bf_32.sv
// r2sdf_bf_32 - first butterfly stage (BF-I) of a 64-point radix-2
// single-delay-feedback FFT. Works with an external 32-entry feedback delay
// line: drives its write side every valid cycle and consumes its oldest entry.
//
// Ports:
//   iClk, iRst_n          clock, async active-low reset
//   iValid, iData_Re/Im   input sample strobe and signed sample (IW bits)
//   oBuf_En, oBuf_Re/Im   delay-line shift enable / write data (combinational)
//   iBuf_Re/Im            delay-line oldest entry (OW bits)
//   oValid, oData_Re/Im   registered output strobe and sample (OW bits)
//   oTwIdx                registered twiddle exponent k for W64^k
//   oFrameStart           registered marker on the first sum of each frame
module r2sdf_bf_32 #(
  parameter int N_HALF = 32,
  parameter int IW     = 32,
  parameter int OW     = 33
) (
  input  logic          iClk,
  input  logic          iRst_n,
  input  logic          iValid,
  input  logic [IW-1:0] iData_Re,
  input  logic [IW-1:0] iData_Im,
  output logic          oBuf_En,
  output logic [OW-1:0] oBuf_Re,
  output logic [OW-1:0] oBuf_Im,
  input  logic [OW-1:0] iBuf_Re,
  input  logic [OW-1:0] iBuf_Im,
  output logic          oValid,
  output logic [OW-1:0] oData_Re,
  output logic [OW-1:0] oData_Im,
  output logic [4:0]    oTwIdx,
  output logic          oFrameStart
);

  localparam int CW = $clog2(2 * N_HALF);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          primed_q, primed_d;
  logic          valid_q, valid_d;
  logic          fs_q, fs_d;
  logic [OW-1:0] data_re_q, data_re_d;
  logic [OW-1:0] data_im_q, data_im_d;
  logic [4:0]    tw_q, tw_d;

  logic          phase_b;
  logic [OW-1:0] x_re, x_im;
  logic [OW-1:0] sum_re, sum_im;
  logic [OW-1:0] dif_re, dif_im;

  always_comb begin
    phase_b = cnt_q[CW-1];
    x_re    = {{(OW-IW){iData_Re[IW-1]}}, iData_Re};
    x_im    = {{(OW-IW){iData_Im[IW-1]}}, iData_Im};
    // 33-bit wrap arithmetic; operands are sign-extended 32-bit values in
    // phase B so neither result can overflow.
    sum_re  = iBuf_Re + x_re;
    sum_im  = iBuf_Im + x_im;
    dif_re  = iBuf_Re - x_re;
    dif_im  = iBuf_Im - x_im;

    oBuf_En = iValid;
    oBuf_Re = phase_b ? dif_re : x_re;
    oBuf_Im = phase_b ? dif_im : x_im;

    cnt_d    = iValid ? cnt_q + CW'(1) : cnt_q;
    // Once a full frame has passed, the delay line holds real differences
    // and phase-A outputs can be released.
    primed_d = primed_q | (iValid & (cnt_q == CW'(2 * N_HALF - 1)));

    valid_d  = iValid & (phase_b | primed_q);
    fs_d     = iValid & (cnt_q == CW'(N_HALF));

    data_re_d = data_re_q;
    data_im_d = data_im_q;
    tw_d      = tw_q;
    if (valid_d) begin
      data_re_d = phase_b ? sum_re : iBuf_Re;
      data_im_d = phase_b ? sum_im : iBuf_Im;
      tw_d      = phase_b ? 5'd0 : 5'(cnt_q[CW-2:0]);
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      cnt_q     <= '0;
      primed_q  <= 1'b0;
      valid_q   <= 1'b0;
      fs_q      <= 1'b0;
      data_re_q <= '0;
      data_im_q <= '0;
      tw_q      <= '0;
    end else begin
      cnt_q     <= cnt_d;
      primed_q  <= primed_d;
      valid_q   <= valid_d;
      fs_q      <= fs_d;
      data_re_q <= data_re_d;
      data_im_q <= data_im_d;
      tw_q      <= tw_d;
    end
  end

  assign oValid      = valid_q;
  assign oFrameStart = fs_q;
  assign oData_Re    = data_re_q;
  assign oData_Im    = data_im_q;
  assign oTwIdx      = tw_q;

endmodule

// File: tb/tb_r2sdf_bf_32.sv
// Bench for r2sdf_bf_32: models the external 32-entry delay line, keeps a
// sample-history reference model, and pins the model with literal checks.
module tb_r2sdf_bf_32;

  logic        iClk = 1'b0;
  logic        iRst_n = 1'b1;
  logic        iValid = 1'b0;
  logic [31:0] iData_Re = '0;
  logic [31:0] iData_Im = '0;
  logic        oBuf_En;
  logic [32:0] oBuf_Re, oBuf_Im;
  logic [32:0] iBuf_Re, iBuf_Im;
  logic        oValid;
  logic [32:0] oData_Re, oData_Im;
  logic [4:0]  oTwIdx;
  logic        oFrameStart;

  always #5 iClk = ~iClk;

  r2sdf_bf_32 dut (
    .iClk(iClk), .iRst_n(iRst_n), .iValid(iValid),
    .iData_Re(iData_Re), .iData_Im(iData_Im),
    .oBuf_En(oBuf_En), .oBuf_Re(oBuf_Re), .oBuf_Im(oBuf_Im),
    .iBuf_Re(iBuf_Re), .iBuf_Im(iBuf_Im),
    .oValid(oValid), .oData_Re(oData_Re), .oData_Im(oData_Im),
    .oTwIdx(oTwIdx), .oFrameStart(oFrameStart)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // External delay line: no reset, seeded with garbage so suppression of
  // stale contents is exercised.
  logic [32:0] dl_re[32];
  logic [32:0] dl_im[32];
  bit          dl_seeded = 1'b0;

  always @(posedge iClk) begin
    if (!dl_seeded) begin
      for (int i = 0; i < 32; i++) begin
        dl_re[i] <= {1'($urandom), $urandom};
        dl_im[i] <= {1'($urandom), $urandom};
      end
      dl_seeded <= 1'b1;
    end else if (oBuf_En) begin
      for (int i = 31; i > 0; i--) begin
        dl_re[i] <= dl_re[i-1];
        dl_im[i] <= dl_im[i-1];
      end
      dl_re[0] <= oBuf_Re;
      dl_im[0] <= oBuf_Im;
    end
  end

  assign iBuf_Re = dl_re[31];
  assign iBuf_Im = dl_im[31];

  // Reference model: valid sample n (since reset) sits at frame position
  // p = n mod 64. p>=32 yields x[n-32]+x[n]; p<32 with a previous frame
  // yields x[n-64]-x[n-32] with twiddle p.
  logic [32:0] hist_re[128];
  logic [32:0] hist_im[128];
  int          n_smp;
  logic        exp_v, exp_fs;
  logic [32:0] exp_re, exp_im;
  logic [4:0]  exp_tw;

  wire [32:0] x_re = {iData_Re[31], iData_Re};
  wire [32:0] x_im = {iData_Im[31], iData_Im};

  always @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      n_smp  <= 0;
      exp_v  <= 1'b0;
      exp_fs <= 1'b0;
      exp_re <= '0;
      exp_im <= '0;
      exp_tw <= '0;
    end else begin
      exp_v  <= 1'b0;
      exp_fs <= 1'b0;
      if (iValid) begin
        hist_re[n_smp % 128] <= x_re;
        hist_im[n_smp % 128] <= x_im;
        n_smp <= n_smp + 1;
        if ((n_smp % 64) >= 32) begin
          exp_v  <= 1'b1;
          exp_re <= hist_re[(n_smp - 32) % 128] + x_re;
          exp_im <= hist_im[(n_smp - 32) % 128] + x_im;
          exp_tw <= 5'd0;
          exp_fs <= ((n_smp % 64) == 32);
        end else if (n_smp >= 64) begin
          exp_v  <= 1'b1;
          exp_re <= hist_re[(n_smp - 64) % 128] - hist_re[(n_smp - 32) % 128];
          exp_im <= hist_im[(n_smp - 64) % 128] - hist_im[(n_smp - 32) % 128];
          exp_tw <= 5'(n_smp % 64);
        end
      end
    end
  end

  typedef struct {
    logic [32:0] re;
    logic [32:0] im;
    logic [4:0]  tw;
    logic        fs;
  } ent_t;
  ent_t log_q[$];
  bit   run_cmp = 1'b0;

  always @(negedge iClk) begin
    if (run_cmp && iRst_n) begin
      chk("buf_en", 64'(oBuf_En), 64'(iValid));
      chk("valid", 64'(oValid), 64'(exp_v));
      if (exp_v && oValid) begin
        chk("data_re", 64'(oData_Re), 64'(exp_re));
        chk("data_im", 64'(oData_Im), 64'(exp_im));
        chk("tw_idx", 64'(oTwIdx), 64'(exp_tw));
        chk("frame_start", 64'(oFrameStart), 64'(exp_fs));
      end else begin
        chk("frame_start_idle", 64'(oFrameStart), 64'(0));
      end
      if (oValid) log_q.push_back('{oData_Re, oData_Im, oTwIdx, oFrameStart});
    end
  end

  task automatic cyc(input logic v, input logic [31:0] re, input logic [31:0] im);
    iValid   = v;
    iData_Re = re;
    iData_Im = im;
    @(posedge iClk);
    #1;
  endtask

  task automatic send(input logic [31:0] re, input logic [31:0] im, input bit gapped);
    if (gapped)
      for (int g = 0; g < 3 && $urandom_range(0, 1) == 1; g++) cyc(1'b0, $urandom, $urandom);
    cyc(1'b1, re, im);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, '0);
  endtask

  // Assert reset mid-cycle; registered outputs must clear at once.
  task automatic do_reset();
    #2;
    iRst_n = 1'b0;
    #1;
    chk("rst_valid", 64'(oValid), 64'(0));
    chk("rst_fs", 64'(oFrameStart), 64'(0));
    chk("rst_re", 64'(oData_Re), 64'(0));
    chk("rst_im", 64'(oData_Im), 64'(0));
    chk("rst_tw", 64'(oTwIdx), 64'(0));
    iValid = 1'b0;
    @(posedge iClk);
    @(posedge iClk);
    #1;
    iRst_n = 1'b1;
    log_q.delete();
  endtask

  task automatic ramp_and_drain(input bit gapped);
    for (int n = 0; n < 64; n++) send(32'(n), '0, gapped);
    for (int n = 0; n < 32; n++) send('0, '0, gapped);
    idle(3);
    chk("ramp_count", 64'(log_q.size()), 64'(64));
    if (log_q.size() == 64) begin
      for (int i = 0; i < 32; i++) begin
        chk("ramp_sum", 64'(log_q[i].re), 64'(32 + 2 * i));
        chk("ramp_sum_im", 64'(log_q[i].im), 64'(0));
        chk("ramp_sum_tw", 64'(log_q[i].tw), 64'(0));
        chk("ramp_fs", 64'(log_q[i].fs), 64'(i == 0));
      end
      for (int i = 0; i < 32; i++) begin
        chk("drain_dif", 64'(log_q[32+i].re), 64'(33'h1FFFFFFE0));
        chk("drain_im", 64'(log_q[32+i].im), 64'(0));
        chk("drain_tw", 64'(log_q[32+i].tw), 64'(i));
        chk("drain_fs", 64'(log_q[32+i].fs), 64'(0));
      end
    end
  endtask

  initial begin
    @(posedge iClk);
    #1;
    do_reset();
    run_cmp = 1'b1;

    ramp_and_drain(1'b0);

    do_reset();
    ramp_and_drain(1'b1);

    do_reset();
    for (int n = 0; n < 40; n++) send(32'(n), '0, 1'b0);
    do_reset();
    ramp_and_drain(1'b0);

    do_reset();
    for (int n = 0; n < 64; n++) send(32'h7FFFFFFF, '0, 1'b0);
    for (int n = 0; n < 32; n++) send(32'h80000000, '0, 1'b0);
    for (int n = 0; n < 32; n++) send(32'h7FFFFFFF, '0, 1'b0);
    for (int n = 0; n < 32; n++) send('0, '0, 1'b0);
    idle(2);
    chk("ext_count", 64'(log_q.size()), 64'(128));
    if (log_q.size() == 128) begin
      chk("ext_sum_max", 64'(log_q[0].re), 64'(33'h0FFFFFFFE));
      chk("ext_sum_max_last", 64'(log_q[31].re), 64'(33'h0FFFFFFFE));
      chk("ext_dif_zero", 64'(log_q[32].re), 64'(0));
      chk("ext_sum_neg", 64'(log_q[64].re), 64'(33'h1FFFFFFFF));
      chk("ext_dif_min", 64'(log_q[96].re), 64'(33'h100000001));
      chk("ext_dif_min_tw", 64'(log_q[127].tw), 64'(31));
    end

    do_reset();
    for (int n = 0; n < 700; n++) send($urandom, $urandom, 1'b1);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/r2sdf_bf_32.md
# r2sdf_bf_32

First butterfly stage (BF-I) of the 64-point radix-2 single-delay-feedback FFT. It pairs with the 32-entry feedback delay line `buffer_32`. Each cycle it drives the write side of that line and consumes its oldest entry. It also emits butterfly sums and differences, with a twiddle index, to the downstream twiddle multiplier. Sample flow is qualified by a valid strobe, and gaps in the strobe stall the stage and its delay line together.

## Interface
- `N_HALF`, default 32, is the delay-line depth and half the frame length. It is fixed at 32, and `cnt` is 6 bits.
- `IW`, default 32, is the input sample width. Samples are signed two's complement.
- `OW`, default 33, is the output and delay-line width. It equals `IW+1`.

Ports:
- `iClk` — in, 1 — clock; all state updates on the rising edge.
- `iRst_n` — in, 1 — reset; asynchronous, active-low.
- `iValid` — in, 1 — input sample strobe.
- `iData_Re`, `iData_Im` — in, 32 each — input sample.
- `oBuf_En` — out, 1 — delay-line shift enable; combinational, equal to `iValid`.
- `oBuf_Re`, `oBuf_Im` — out, 33 each — delay-line write data; combinational.
- `iBuf_Re`, `iBuf_Im` — in, 33 each — delay-line oldest entry.
- `oValid` — out, 1 — output sample strobe; registered.
- `oData_Re`, `oData_Im` — out, 33 each — stage output; registered.
- `oTwIdx` — out, 5 — twiddle exponent k for W64^k; registered.
- `oFrameStart` — out, 1 — marks the first sum of each frame; registered.

## Operation
- **Counter:** `cnt` is 6 bits and advances on each `iValid`, wrapping from 63 to 0.
  - Phase A is `cnt[5]=0`.
  - Phase B is `cnt[5]=1`.
- **Sign extension:** `x` is the input sign-extended to 33 bits. `b` is the 33-bit value on `iBuf_*`.
- **Phase A, bypass:**
  - The delay line is written with `x`.
  - The output candidate is `b`, which is the difference stored during the previous frame's phase B.
  - The twiddle index is `cnt[4:0]`.
- **Phase B, butterfly:**
  - The output candidate is `b + x`.
  - The delay line is written with `b − x`.
  - The twiddle index is 0.
- **Width rule:** `b` holds a sign-extended 32-bit value during phase B. Both results therefore fit in 33 bits and no saturation logic exists. Arithmetic is 33-bit wrap.
- **Priming flag:** `primed` resets to 0 and is set when `cnt` wraps from 63 to 0 under `iValid`. It is never cleared except by reset.
  - Phase-A candidates are emitted only when `primed=1`. This suppresses stale delay-line contents after reset; the delay line itself has no reset.
  - Phase-B candidates are always emitted.
- **Output valid:** `oValid` equals `iValid & (cnt[5] | primed)`, registered.
- **Frame start:** `oFrameStart` is 1 with the output produced at `cnt=32`.
- **Stall:** while `iValid=0`, the following all hold their values: `cnt`, `primed`, and the delay line (since `oBuf_En=0`). `oValid` is 0.
- **Draining:** the last frame's differences are flushed only by supplying 32 further valid samples. Those samples start the next frame.

## Timing
- **Reset values:**
  - `oValid=0`, `oFrameStart=0`.
  - `oData_Re/Im=0`, `oTwIdx=0`.
  - `cnt=0`, `primed=0`.
- **Reset timing:** assertion takes effect immediately. Deassertion is synchronised by the top level.
- **Latency:** one cycle from the `iValid` sample to the corresponding `oValid`.
- **Sequence from reset:**
  - The first 32 valid inputs produce no output.
  - Inputs 32–63 produce 32 sums.
  - From input 64 on, every valid input produces one output.
- **Combinational path:** the write-side paths `oBuf_*` and `oBuf_En` are combinational from `iValid`, `iData_*`, `iBuf_*` and `cnt`. The delay line registers them.
- **Reset mid-frame:** `cnt` and `primed` clear. The next 32 valid inputs overwrite the whole delay line before any phase-B read, so no stale data reaches the outputs.
- **Wrap and output priority:** at the `cnt` 63→0 wrap, `primed` is set on the same edge. The phase-A output at `cnt=0` is emitted one cycle later.
- **Valid pattern:** `iValid` may toggle every cycle. Output order is identical to the order with continuous valid.

## Test plan
- **Reset:** assert `iRst_n=0` mid-stream.
  - All registered outputs must read 0 immediately.
  - After release, 32 valid inputs must give `oValid=0` throughout.
- **Ramp frame:** feed Re=n, Im=0 for n=0..63 continuously.
  - `oValid` rises 1 cycle after n=32.
  - Outputs are Re=32,34,…,94, each with `oTwIdx=0`.
  - `oFrameStart=1` on the first of these outputs only.
- **Difference drain:** follow the ramp with 32 zero samples.
  - Outputs are Re=−32 for k=0..31, with `oTwIdx`=0..31.
  - Im=0 throughout.
- **Extremes:** feed Re=0x7FFFFFFF (phase A) against Re=0x7FFFFFFF (phase B).
  - The sum is 0x0FFFFFFFE in 33 bits.
  - Next-frame difference is 0.
  - Repeat with 0x80000000 against 0x7FFFFFFF: the difference is 33-bit −(2^32−1).
- **Gapped valid:** repeat the ramp with `iValid` at 50% random duty.
  - The output values and order must be identical to the continuous case.
  - `oBuf_En` must equal `iValid` every cycle.
- **Reset mid-frame:** reset after 40 ramp samples, then feed a fresh ramp.
  - The results must match the clean ramp case exactly, with no −32 or stale values emitted before the first sum.
